// File: rtl/issue_scheduler_pkg.sv
// Shared types and default sizes for the single-issue ROB scheduler.
// State encoding follows the order IDLE, REQ, BUSY, DRAIN.
package issue_scheduler_pkg;

    localparam int ROB_SIZE_DEF     = 4;
    localparam int ROB_SIZE_LOG_DEF = 2;
    localparam int CNT_LEN_DEF      = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/issue_scheduler_age_picker.sv
// Oldest-ready picker: scans offsets from rob_head and returns the first READY entry.
module age_picker
    import issue_scheduler_pkg::*;
#(
    parameter int ROB_SIZE     = ROB_SIZE_DEF,
    parameter int ROB_SIZE_LOG = ROB_SIZE_LOG_DEF
) (
    input  logic [ROB_SIZE-1:0]     ready_vec,
    input  logic [ROB_SIZE_LOG-1:0] rob_head,
    output logic                    pick_valid,
    output logic [ROB_SIZE_LOG-1:0] pick_idx
);

    // Scanning from the youngest offset down lets the oldest match win.
    always_comb begin
        logic [ROB_SIZE_LOG-1:0] w_idx;
        pick_valid = |ready_vec;
        pick_idx   = '0;
        w_idx      = '0;
        for (int k = ROB_SIZE - 1; k >= 0; k--) begin
            w_idx = rob_head + ROB_SIZE_LOG'(k);
            if (ready_vec[w_idx]) pick_idx = w_idx;
        end
    end

endmodule

// File: rtl/issue_scheduler.sv
// Single-issue scheduler: picks the oldest READY ROB entry, tracks one in-flight
// operation on the shared execute unit, and suppresses results after a squash.
module issue_scheduler
    import issue_scheduler_pkg::*;
#(
    parameter int ROB_SIZE     = ROB_SIZE_DEF,
    parameter int ROB_SIZE_LOG = ROB_SIZE_LOG_DEF,
    parameter int CNT_LEN      = CNT_LEN_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ROB_SIZE-1:0]     ready_vec,
    input  logic [ROB_SIZE_LOG-1:0] rob_head,
    input  logic                    squash,
    output logic                    issue_valid,
    output logic [ROB_SIZE_LOG-1:0] issue_idx,
    input  logic                    issue_ack,
    output logic                    issued,
    input  logic                    exec_done,
    output logic                    complete_valid,
    output logic [ROB_SIZE_LOG-1:0] complete_idx,
    output logic                    busy,
    output logic [CNT_LEN-1:0]      issue_count
);

    state_e                  r_state;
    state_e                  w_next;
    logic [ROB_SIZE_LOG-1:0] r_issue_idx;
    logic [CNT_LEN-1:0]      r_issue_count;
    logic                    w_pick_valid;
    logic [ROB_SIZE_LOG-1:0] w_pick_idx;
    logic                    w_issue_valid;
    logic                    w_issued;
    logic                    w_complete;

    age_picker #(
        .ROB_SIZE     (ROB_SIZE),
        .ROB_SIZE_LOG (ROB_SIZE_LOG)
    ) u_picker (
        .ready_vec  (ready_vec),
        .rob_head   (rob_head),
        .pick_valid (w_pick_valid),
        .pick_idx   (w_pick_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_issue_idx   <= '0;
            r_issue_count <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && w_next == ST_REQ) r_issue_idx <= w_pick_idx;
            // An ack counts even alongside squash: the unit already took the op.
            if (w_issued) r_issue_count <= r_issue_count + CNT_LEN'(1);
        end
    end

    // Squash takes priority in every state.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (!squash && w_pick_valid) w_next = ST_REQ;
            ST_REQ: begin
                if (squash)         w_next = issue_ack ? ST_DRAIN : ST_IDLE;
                else if (issue_ack) w_next = ST_BUSY;
            end
            ST_BUSY: begin
                if (squash)         w_next = exec_done ? ST_IDLE : ST_DRAIN;
                else if (exec_done) w_next = ST_IDLE;
            end
            ST_DRAIN: if (!squash && exec_done) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // issue_valid decodes only registered state, so no input reaches it combinationally.
    always_comb begin
        w_issue_valid = (r_state == ST_REQ);
        w_issued      = w_issue_valid && issue_ack;
        w_complete    = (r_state == ST_BUSY) && exec_done && !squash;
    end

    assign issue_valid    = w_issue_valid;
    assign issue_idx      = r_issue_idx;
    assign issued         = w_issued;
    assign complete_valid = w_complete;
    assign complete_idx   = r_issue_idx;
    assign busy           = (r_state != ST_IDLE);
    assign issue_count    = r_issue_count;

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed and randomized bench for issue_scheduler against an abstract reference model.
module tb_issue_scheduler;

    localparam int RS = 4;
    localparam int RL = 2;
    localparam int CL = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [RS-1:0] ready_vec;
    logic [RL-1:0] rob_head;
    logic          squash, issue_ack, exec_done;
    logic          issue_valid, issued, complete_valid, busy;
    logic [RL-1:0] issue_idx, complete_idx;
    logic [CL-1:0] issue_count;

    int tests = 0;
    int fails = 0;

    // Model: requesting, running (result wanted), stale (result to discard).
    bit            m_req, m_run, m_stale;
    logic [RL-1:0] m_idx;
    logic [CL-1:0] m_cnt;

    issue_scheduler #(.ROB_SIZE(RS), .ROB_SIZE_LOG(RL), .CNT_LEN(CL)) dut (
        .clk            (clk),
        .rst            (rst),
        .ready_vec      (ready_vec),
        .rob_head       (rob_head),
        .squash         (squash),
        .issue_valid    (issue_valid),
        .issue_idx      (issue_idx),
        .issue_ack      (issue_ack),
        .issued         (issued),
        .exec_done      (exec_done),
        .complete_valid (complete_valid),
        .complete_idx   (complete_idx),
        .busy           (busy),
        .issue_count    (issue_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RL:0] ref_pick(input logic [RS-1:0] rv, input logic [RL-1:0] h);
        for (int k = 0; k < RS; k++) begin
            int i;
            i = (int'(h) + k) % RS;
            if (rv[i]) return {1'b1, RL'(i)};
        end
        return '0;
    endfunction

    task automatic model_step();
        logic [RL:0] p;
        p = ref_pick(ready_vec, rob_head);
        if (!rst) begin
            m_req = 0; m_run = 0; m_stale = 0; m_idx = '0; m_cnt = '0;
        end else if (m_req) begin
            if (issue_ack) begin
                m_cnt = m_cnt + 1'b1;
                m_req = 0;
                if (squash) m_stale = 1; else m_run = 1;
            end else if (squash) begin
                m_req = 0;
            end
        end else if (m_run) begin
            if (squash) begin
                m_run = 0;
                m_stale = !exec_done;
            end else if (exec_done) begin
                m_run = 0;
            end
        end else if (m_stale) begin
            if (exec_done && !squash) m_stale = 0;
        end else if (p[RL] && !squash) begin
            m_req = 1;
            m_idx = p[RL-1:0];
        end
    endtask

    task automatic drive(input logic r, input logic [RS-1:0] rv, input logic [RL-1:0] h,
                         input logic sq, input logic ak, input logic dn);
        rst = r; ready_vec = rv; rob_head = h; squash = sq; issue_ack = ak; exec_done = dn;
    endtask

    // Check all outputs against the model, cross the edge, advance the model.
    task automatic tick();
        #1;
        chk("issue_valid",    issue_valid,    m_req);
        chk("issue_idx",      issue_idx,      m_idx);
        chk("issued",         issued,         m_req && issue_ack);
        chk("complete_valid", complete_valid, m_run && exec_done && !squash);
        chk("complete_idx",   complete_idx,   m_idx);
        chk("busy",           busy,           m_req || m_run || m_stale);
        chk("issue_count",    issue_count,    m_cnt);
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic chk_state(input string tag, input logic [1:0] exp);
        logic [1:0] st;
        st = dut.r_state;
        chk(tag, st, exp);
    endtask

    initial begin
        m_req = 0; m_run = 0; m_stale = 0; m_idx = '0; m_cnt = '0;
        drive(0, 4'b0000, 2'd0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        tick();
        chk_state("reset_state", 2'd0);

        // Single issue, head 0, entry 2 ready.
        drive(1, 4'b0100, 2'd0, 0, 0, 0);
        tick();
        chk("t1_valid", issue_valid, 1);
        chk("t1_idx", issue_idx, 2);
        tick();
        drive(1, 4'b0100, 2'd0, 0, 1, 0);
        tick();
        drive(1, 4'b0000, 2'd0, 0, 0, 1);
        #1;
        chk("t1_complete", complete_valid, 1);
        chk("t1_cidx", complete_idx, 2);
        tick();
        chk("t1_count", issue_count, 1);
        chk_state("t1_idle", 2'd0);

        // Age wrap: head 3, entries 0 and 1 ready.
        drive(1, 4'b0011, 2'd3, 0, 0, 0);
        tick();
        chk("wrap1_idx", issue_idx, 0);
        drive(1, 4'b0000, 2'd0, 1, 0, 0);
        tick();
        chk("wrap1_drop", issue_valid, 0);
        drive(1, 4'b1001, 2'd1, 0, 0, 0);
        tick();
        chk("wrap2_idx", issue_idx, 3);

        // Backpressure for five cycles.
        drive(1, 4'b1111, 2'd0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", issue_valid, 1);
            chk("bp_idx", issue_idx, 3);
        end
        chk("bp_count", issue_count, 1);

        // Accept, then squash in BUSY, then late exec_done.
        drive(1, 4'b0000, 2'd0, 0, 1, 0);
        tick();
        chk_state("sqb_busy", 2'd2);
        drive(1, 4'b0000, 2'd0, 1, 0, 0);
        tick();
        chk_state("sqb_drain", 2'd3);
        drive(1, 4'b0000, 2'd0, 0, 0, 0);
        tick();
        drive(1, 4'b0000, 2'd0, 0, 0, 1);
        #1;
        chk("sqb_no_complete", complete_valid, 0);
        tick();
        chk_state("sqb_idle", 2'd0);
        chk("sqb_count", issue_count, 2);

        // Squash and ack in the same REQ cycle.
        drive(1, 4'b0001, 2'd0, 0, 0, 0);
        tick();
        drive(1, 4'b0000, 2'd0, 1, 1, 0);
        #1;
        chk("sqa_issued", issued, 1);
        tick();
        chk_state("sqa_drain", 2'd3);
        chk("sqa_count", issue_count, 3);
        drive(1, 4'b0000, 2'd0, 0, 0, 1);
        tick();
        chk_state("sqa_idle", 2'd0);

        // Reset while BUSY.
        drive(1, 4'b0010, 2'd0, 0, 0, 0);
        tick();
        drive(1, 4'b0000, 2'd0, 0, 1, 0);
        tick();
        drive(0, 4'b0000, 2'd0, 0, 0, 0);
        tick();
        chk_state("rst_idle", 2'd0);
        chk("rst_count", issue_count, 0);
        chk("rst_busy", busy, 0);
        drive(1, 4'b0000, 2'd0, 0, 0, 1);
        tick();
        chk_state("rst_ignore_done", 2'd0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(63) != 0), 4'($urandom_range(15)), 2'($urandom_range(3)),
                  ($urandom_range(7) == 0), ($urandom_range(1) == 1), ($urandom_range(2) == 0));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

Single-issue scheduler for the out-of-order core's ROB. It selects the oldest READY ROB entry and hands it to one shared, multi-cycle execute unit. It tracks that unit's single in-flight operation and reports completions back to the ROB. On a commit-time squash it discards any in-flight result.

## Interface
Parameters:
- ROB_SIZE, 4, number of ROB entries; must be a power of two.
- ROB_SIZE_LOG, 2, log2(ROB_SIZE); width of every ROB index.
- CNT_LEN, 8, width of the issue counter.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-low: rst==0 at a rising edge resets the block.
- ready_vec  in  ROB_SIZE  bit i set means ROB entry i is READY. The ROB clears bit i the cycle after `issued` names entry i.
- rob_head  in  ROB_SIZE_LOG  index of the oldest ROB entry; this is the age reference.
- squash  in  1  commit-time squash (C_valid && C_squash).
- issue_valid  out  1  request to the execute unit; registered.
- issue_idx  out  ROB_SIZE_LOG  ROB entry being requested; registered; stable while issue_valid is high.
- issue_ack  in  1  the execute unit accepts the request this cycle.
- issued  out  1  combinational, equal to issue_valid && issue_ack. The ROB marks entry issue_idx EXECUTING on this pulse.
- exec_done  in  1  the execute unit returns its result this cycle.
- complete_valid  out  1  combinational. The result of complete_idx is valid this cycle; the ROB writes it and sets the entry FINISHED.
- complete_idx  out  ROB_SIZE_LOG  ROB index of the in-flight operation.
- busy  out  1  high when state is not IDLE.
- issue_count  out  CNT_LEN  number of accepted issues since reset; wraps modulo 2^CNT_LEN.

## Operation
The state machine has four states: IDLE, REQ, BUSY, DRAIN. Encoding is 2 bits, in the order listed.

Age picker:
- Scan offsets k = 0 .. ROB_SIZE-1. The index is (rob_head + k) mod ROB_SIZE, taken as a natural ROB_SIZE_LOG-bit wrap.
- The pick is the first index whose ready_vec bit is set.
- `pick_valid` is the OR of ready_vec.

Transitions (squash is evaluated first in every state):
- IDLE: if pick_valid and not squash, latch the pick into issue_idx and go to REQ. Otherwise stay in IDLE.
- REQ:
  - squash and issue_ack together: go to DRAIN. The execute unit has already taken the operation; `issued` still pulses.
  - squash without issue_ack: go to IDLE.
  - issue_ack without squash: go to BUSY and increment issue_count.
  - neither: stay in REQ and hold issue_idx.
- BUSY:
  - squash: go to DRAIN. If exec_done is also high, go to IDLE instead. In both cases complete_valid stays low.
  - exec_done: assert complete_valid and go to IDLE.
- DRAIN: on exec_done go to IDLE with complete_valid low. squash here keeps the block in DRAIN.

Rules that hold in every state:
- issue_valid is 1 exactly in REQ.
- complete_valid is asserted only in BUSY.
- exec_done outside BUSY and DRAIN is ignored.
- issue_count also increments on the REQ + squash + ack case, because that issue was accepted by the execute unit.
- At most one operation is in flight at any time.

## Timing
- Reset (rst==0 at an edge): state IDLE, issue_valid 0, issue_idx 0, issue_count 0.
  - busy, complete_valid and issued read 0 the cycle after reset.
  - complete_idx follows issue_idx.
- Latency from a ready bit rising (cycle t) to issue_valid is cycle t+1.
- The minimum period between successive issues is 3 cycles: REQ, then BUSY with exec_done in the same cycle, then IDLE.
- A squash at cycle t drops issue_valid at cycle t+1.
- A stale exec_done after squash is never reported.
- No combinational path exists from squash, ready_vec or rob_head to issue_valid or issue_idx.

## Structure
- State encodings IDLE/REQ/BUSY/DRAIN go in param.v as `define constants, next to the ROB_SIZE and ROB_SIZE_LOG defines already there.
- The picker is a natural sub-module, `age_picker` (inputs: ready_vec, rob_head; outputs: pick_valid, pick_idx), written as a loop over offsets.
- Everything else stays in a single always block plus combinational assigns.

## Test plan
- Single issue with head=0 and ready_vec=0b0100:
  - required: issue_valid the next cycle with idx=2.
  - ack one cycle later, then exec_done the following cycle: required complete_valid=1 with idx=2, issue_count=1, back in IDLE.
- Age wrap with head=3 and ready_vec=0b0011: required pick idx=0.
  - With head=1 and ready_vec=0b1001: required pick idx=3.
- Backpressure: hold issue_ack=0 for 5 cycles. Required: issue_valid and issue_idx stable throughout, issued=0, issue_count unchanged.
- Squash in BUSY, then exec_done 2 cycles later. Required: complete_valid stays 0, the block goes to DRAIN and then IDLE, issue_count=1.
- Squash and issue_ack in the same REQ cycle. Required: issued=1, next state DRAIN, issue_count incremented, and the following exec_done is suppressed.
- Reset mid-operation: drive rst=0 while in BUSY. Required: next cycle state is IDLE, issue_count=0, busy=0, and a later exec_done is ignored.
